// File: rtl/timer_counter.sv
// timer_counter: memory-mapped programmable down-counter with a maskable level IRQ.
// Define TC_PRESCALE_EN to add a PS_W-bit prescaler controlled by CTRL[3+PS_W:4].
module timer_counter #(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000,
  parameter int          PS_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

`ifdef TC_PRESCALE_EN
  localparam int CTRL_W = 4 + PS_W;
`else
  localparam int CTRL_W = 4;
  localparam int unused_ps_w = PS_W;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       preset_q, preset_d;
  logic [31:0]       count_q, count_d;
  logic              irq_flag_q, irq_flag_d;
  logic              en, im, auto_reload, tick;
  logic              unused_addr;

  assign en          = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign im          = ctrl_q[3];
  assign unused_addr = ^Addr[31:4];

`ifdef TC_PRESCALE_EN
  logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
  assign tick = (ps_cnt_q == ctrl_q[CTRL_W-1:4]);
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
`ifdef TC_PRESCALE_EN
    ps_cnt_d   = ps_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (en) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
`ifdef TC_PRESCALE_EN
        ps_cnt_d = '0;
`endif
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (tick) begin
`ifdef TC_PRESCALE_EN
          ps_cnt_d = '0;
`endif
          // PRESET 0 and 1 both terminate on the first CNT cycle; never wraps below 0
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d    = '0;
            irq_flag_d = 1'b1;
            state_d    = INT;
          end
        end
`ifdef TC_PRESCALE_EN
        else begin
          ps_cnt_d = ps_cnt_q + {{(PS_W-1){1'b0}}, 1'b1};
        end
`endif
      end
      INT: begin
        if (auto_reload) begin
          irq_flag_d = 1'b0;
          state_d    = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // CPU write applied last so it overrides whatever the FSM did to CTRL/irq_flag
    if (WE) begin
      case (Addr[3:2])
        2'd0: begin
          ctrl_d     = Din[CTRL_W-1:0];
          irq_flag_d = 1'b0;
        end
        2'd1: preset_d = Din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= PRESET_RST;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
`ifdef TC_PRESCALE_EN
      ps_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
`ifdef TC_PRESCALE_EN
      ps_cnt_q   <= ps_cnt_d;
`endif
    end
  end

  always_comb begin
    case (Addr[3:2])
      2'd0:    Dout = 32'(ctrl_q);
      2'd1:    Dout = preset_q;
      2'd2:    Dout = count_q;
      default: Dout = '0;
    endcase
  end

  assign IRQ = irq_flag_q & im;

endmodule
